// File: rtl/mat_reg_file.sv
// Multi-bank WIDTH x WIDTH signed matrix register file with a row-sequenced COPY/TRANSPOSE engine.
// Define MAT_REG_FILE_ACC_EN to build the saturating ACC_ROW datapath; otherwise op 7 acts as NOP.
module mat_reg_file #(
    parameter int WIDTH      = 8,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 4,
    localparam int IDX_W     = $clog2(WIDTH),
    localparam int REG_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_op,
    input  logic [REG_W-1:0]              cmd_dst,
    input  logic [REG_W-1:0]              cmd_src,
    input  logic [IDX_W-1:0]              cmd_p1,
    input  logic [IDX_W-1:0]              cmd_p2,
    input  logic [WIDTH*DATA_WIDTH-1:0]   cmd_data,
    input  logic                          rd_en,
    input  logic [1:0]                    rd_op,
    input  logic [REG_W-1:0]              rd_reg,
    input  logic [IDX_W-1:0]              rd_p1,
    input  logic [IDX_W-1:0]              rd_p2,
    output logic                          rd_valid,
    output logic [WIDTH*DATA_WIDTH-1:0]   rd_data,
    output logic                          busy,
    output logic                          done
);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    typedef enum logic [2:0] {
        OP_NOP, OP_ZERO, OP_ROW, OP_COL, OP_SCALAR, OP_COPY, OP_TRANSPOSE, OP_ACC_ROW
    } cmd_op_t;

    typedef enum logic [1:0] {RD_ROW, RD_COL, RD_SCALAR, RD_DIAG} rd_op_t;

    typedef logic signed [DATA_WIDTH-1:0] entry_t;

    state_t                        state_q, state_d;
    logic [IDX_W-1:0]              row_q, row_d;
    logic [REG_W-1:0]              dst_q, dst_d, src_q, src_d;
    logic                          tp_q, tp_d;
    logic                          done_q, done_d;
    logic                          rd_valid_q, rd_valid_d;
    logic [WIDTH*DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    entry_t                        mem_q [NUM_REGS][WIDTH][WIDTH];
    entry_t                        mem_d [NUM_REGS][WIDTH][WIDTH];

    function automatic logic bank_ok(input logic [REG_W-1:0] b);
        return int'(b) < NUM_REGS;
    endfunction

`ifdef MAT_REG_FILE_ACC_EN
    function automatic entry_t sat_add(input entry_t a, input entry_t b);
        logic signed [DATA_WIDTH:0] s;
        s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        if (s[DATA_WIDTH] != s[DATA_WIDTH-1])
            return s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        return s[DATA_WIDTH-1:0];
    endfunction
`endif

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN);
    assign done      = done_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

    always_comb begin
        // NOTE: every _d starts as its _q copy so no path through the case leaves a latch behind.
        mem_d   = mem_q;
        state_d = state_q;
        row_d   = row_q;
        dst_d   = dst_q;
        src_d   = src_q;
        tp_d    = tp_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op_t'(cmd_op))
                        OP_ZERO: begin
                            if (bank_ok(cmd_dst))
                                for (int i = 0; i < WIDTH; i++)
                                    for (int j = 0; j < WIDTH; j++)
                                        mem_d[cmd_dst][i][j] = '0;
                        end
                        OP_ROW: begin
                            if (bank_ok(cmd_dst))
                                for (int k = 0; k < WIDTH; k++)
                                    mem_d[cmd_dst][cmd_p1][k] = cmd_data[k*DATA_WIDTH +: DATA_WIDTH];
                        end
                        OP_COL: begin
                            if (bank_ok(cmd_dst))
                                for (int k = 0; k < WIDTH; k++)
                                    mem_d[cmd_dst][k][cmd_p1] = cmd_data[k*DATA_WIDTH +: DATA_WIDTH];
                        end
                        OP_SCALAR: begin
                            if (bank_ok(cmd_dst))
                                mem_d[cmd_dst][cmd_p1][cmd_p2] = cmd_data[DATA_WIDTH-1:0];
                        end
`ifdef MAT_REG_FILE_ACC_EN
                        OP_ACC_ROW: begin
                            if (bank_ok(cmd_dst))
                                for (int k = 0; k < WIDTH; k++)
                                    mem_d[cmd_dst][cmd_p1][k] =
                                        sat_add(mem_q[cmd_dst][cmd_p1][k],
                                                cmd_data[k*DATA_WIDTH +: DATA_WIDTH]);
                        end
`endif
                        default: ;
                    endcase

                    if (cmd_op == OP_COPY || cmd_op == OP_TRANSPOSE) begin
                        state_d = ST_RUN;
                        row_d   = '0;
                        dst_d   = cmd_dst;
                        src_d   = cmd_src;
                        tp_d    = (cmd_op == OP_TRANSPOSE);
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                // In-place transpose swaps only the upper triangle of row r; earlier rows never touch it.
                if (bank_ok(dst_q) && bank_ok(src_q)) begin
                    for (int j = 0; j < WIDTH; j++) begin
                        if (!tp_q) begin
                            mem_d[dst_q][row_q][j] = mem_q[src_q][row_q][j];
                        end else if (dst_q != src_q) begin
                            mem_d[dst_q][row_q][j] = mem_q[src_q][j][row_q];
                        end else if (IDX_W'(j) > row_q) begin
                            mem_d[dst_q][row_q][j] = mem_q[dst_q][j][row_q];
                            mem_d[dst_q][j][row_q] = mem_q[dst_q][row_q][j];
                        end
                    end
                end
                if (row_q == IDX_W'(WIDTH - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    row_d   = row_q + 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        if (rd_en) begin
            rd_data_d = '0;
            if (bank_ok(rd_reg)) begin
                case (rd_op_t'(rd_op))
                    RD_ROW:
                        for (int k = 0; k < WIDTH; k++)
                            rd_data_d[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_reg][rd_p1][k];
                    RD_COL:
                        for (int k = 0; k < WIDTH; k++)
                            rd_data_d[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_reg][k][rd_p1];
                    RD_SCALAR:
                        rd_data_d[DATA_WIDTH-1:0] = mem_q[rd_reg][rd_p1][rd_p2];
                    RD_DIAG:
                        for (int k = 0; k < WIDTH; k++)
                            rd_data_d[k*DATA_WIDTH +: DATA_WIDTH] =
                                mem_q[rd_reg][k][rd_p1 - IDX_W'(k)];
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the banks are architecturally visible state that must read 0 after reset, so they are reset flops rather than a RAM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            dst_q      <= '0;
            src_q      <= '0;
            tp_q       <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            for (int b = 0; b < NUM_REGS; b++)
                for (int i = 0; i < WIDTH; i++)
                    for (int j = 0; j < WIDTH; j++)
                        mem_q[b][i][j] <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            dst_q      <= dst_d;
            src_q      <= src_d;
            tp_q       <= tp_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            mem_q      <= mem_d;
        end
    end

endmodule
